// File: rtl/dac_write_scheduler_if.sv
// dac_write_scheduler_if: requester handshake plus DAC pin bundle for dac_write_scheduler
interface dac_write_scheduler_if;
  logic       req_a;
  logic [7:0] data_a;
  logic       ack_a;
  logic       req_b;
  logic [7:0] data_b;
  logic       ack_b;
  logic       busy;
  logic       dac_csn;
  logic       dac_wrn;
  logic       dac_a_b;
  logic [7:0] dac_d;
  logic       dac_ldacn;
  modport master (
    output req_a, data_a, req_b, data_b,
    input  ack_a, ack_b, busy, dac_csn, dac_wrn, dac_a_b, dac_d, dac_ldacn
  );
  modport slave (
    input  req_a, data_a, req_b, data_b,
    output ack_a, ack_b, busy, dac_csn, dac_wrn, dac_a_b, dac_d, dac_ldacn
  );
endinterface

// File: rtl/dac_write_scheduler.sv
// dac_write_scheduler: round-robin A/B arbiter driving parallel DAC write timing, batching A+B under one ldacn pulse
module dac_write_scheduler #(
  parameter int SETUP_CYC = 4,
  parameter int WR_CYC    = 50,
  parameter int HOLD_CYC  = 4,
  parameter int LDAC_CYC  = 8
) (
  input logic clk,
  input logic rst,
  dac_write_scheduler_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SETUP, WRITE, HOLD, LOAD} state_t;
  state_t     state, state_n;
  logic [7:0] cnt, cnt_n, d, d_n;
  logic       ack_a, ack_a_n, ack_b, ack_b_n, busy, busy_n;
  logic       csn, csn_n, wrn, wrn_n, a_b, a_b_n, ldacn, ldacn_n;
  logic       last_b, last_b_n, wr_a, wr_a_n, wr_b, wr_b_n;
  logic       grant_a, grant_b, done;
  assign done = cnt == 8'd0;
  always_comb begin
    grant_a  = 1'b0;
    grant_b  = 1'b0;
    state_n  = state;
    cnt_n    = done ? cnt : cnt - 8'd1;
    ack_a_n  = 1'b0;
    ack_b_n  = 1'b0;
    csn_n    = csn;
    wrn_n    = wrn;
    ldacn_n  = ldacn;
    d_n      = d;
    a_b_n    = a_b;
    last_b_n = last_b;
    wr_a_n   = wr_a;
    wr_b_n   = wr_b;
    case (state)
      IDLE: begin
        grant_a = bus.req_a & (~bus.req_b | last_b);
        grant_b = bus.req_b & (~bus.req_a | ~last_b);
      end
      SETUP: if (done) begin
        state_n = WRITE;
        cnt_n   = 8'(WR_CYC - 1);
        wrn_n   = 1'b0;
      end
      WRITE: if (done) begin
        state_n = HOLD;
        cnt_n   = 8'(HOLD_CYC - 1);
        wrn_n   = 1'b1;
      end
      HOLD: if (done) begin
        // the channel just written is flagged, so only the other one can join the batch
        grant_a = bus.req_a & ~wr_a;
        grant_b = bus.req_b & ~wr_b;
        if (!(grant_a | grant_b)) begin
          state_n = LOAD;
          cnt_n   = 8'(LDAC_CYC - 1);
          csn_n   = 1'b1;
          ldacn_n = 1'b0;
        end
      end
      LOAD: if (done) begin
        state_n = IDLE;
        ldacn_n = 1'b1;
        wr_a_n  = 1'b0;
        wr_b_n  = 1'b0;
      end
      default: state_n = IDLE;
    endcase
    if (grant_a | grant_b) begin
      state_n  = SETUP;
      cnt_n    = 8'(SETUP_CYC - 1);
      ack_a_n  = grant_a;
      ack_b_n  = grant_b;
      d_n      = grant_b ? bus.data_b : bus.data_a;
      a_b_n    = grant_b;
      csn_n    = 1'b0;
      last_b_n = grant_b;
      wr_a_n   = wr_a | grant_a;
      wr_b_n   = wr_b | grant_b;
    end
    busy_n = state_n != IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= 8'd0;
      ack_a  <= 1'b0;
      ack_b  <= 1'b0;
      busy   <= 1'b0;
      csn    <= 1'b1;
      wrn    <= 1'b1;
      ldacn  <= 1'b1;
      a_b    <= 1'b0;
      d      <= 8'h00;
      last_b <= 1'b1;
      wr_a   <= 1'b0;
      wr_b   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      ack_a  <= ack_a_n;
      ack_b  <= ack_b_n;
      busy   <= busy_n;
      csn    <= csn_n;
      wrn    <= wrn_n;
      ldacn  <= ldacn_n;
      a_b    <= a_b_n;
      d      <= d_n;
      last_b <= last_b_n;
      wr_a   <= wr_a_n;
      wr_b   <= wr_b_n;
    end
  end
  assign bus.ack_a     = ack_a;
  assign bus.ack_b     = ack_b;
  assign bus.busy      = busy;
  assign bus.dac_csn   = csn;
  assign bus.dac_wrn   = wrn;
  assign bus.dac_a_b   = a_b;
  assign bus.dac_d     = d;
  assign bus.dac_ldacn = ldacn;
endmodule

// File: tb/tb_dac_write_scheduler.sv
// tb_dac_write_scheduler: directed vectors plus random traffic against a window-arithmetic model, two parameter sets
module tb_dac_write_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  dac_write_scheduler_if bus0 ();
  dac_write_scheduler_if bus1 ();
  dac_write_scheduler #(.SETUP_CYC(2), .WR_CYC(4), .HOLD_CYC(2), .LDAC_CYC(3)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  dac_write_scheduler #(.SETUP_CYC(1), .WR_CYC(255), .HOLD_CYC(1), .LDAC_CYC(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  logic       ra [2] = '{1'b0, 1'b0};
  logic       rb [2] = '{1'b0, 1'b0};
  logic [7:0] da [2] = '{8'h00, 8'h00};
  logic [7:0] db [2] = '{8'h00, 8'h00};
  assign bus0.req_a = ra[0];
  assign bus0.req_b = rb[0];
  assign bus0.data_a = da[0];
  assign bus0.data_b = db[0];
  assign bus1.req_a = ra[1];
  assign bus1.req_b = rb[1];
  assign bus1.data_a = da[1];
  assign bus1.data_b = db[1];
  // packed as {ack_a, ack_b, busy, csn, wrn, a_b, d[7:0], ldacn}
  logic [14:0] obs [2];
  assign obs[0] = {bus0.ack_a, bus0.ack_b, bus0.busy, bus0.dac_csn, bus0.dac_wrn, bus0.dac_a_b, bus0.dac_d, bus0.dac_ldacn};
  assign obs[1] = {bus1.ack_a, bus1.ack_b, bus1.busy, bus1.dac_csn, bus1.dac_wrn, bus1.dac_a_b, bus1.dac_d, bus1.dac_ldacn};
  int s_c [2] = '{2, 1};
  int w_c [2] = '{4, 255};
  int h_c [2] = '{2, 1};
  int l_c [2] = '{3, 1};
  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  // model: g = cycle whose closing edge granted the current write, l = cycle whose closing edge started LOAD
  int         g [2];
  int         l [2];
  logic       mab [2];
  logic       last_b [2];
  logic       wa [2];
  logic       wb [2];
  logic [7:0] md [2];
  task automatic chk(input string name, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask
  task automatic model_init(input int i);
    g[i] = -1000000;
    l[i] = -1000000;
    mab[i] = 1'b0;
    md[i] = 8'h00;
    last_b[i] = 1'b1;
    wa[i] = 1'b0;
    wb[i] = 1'b0;
  endtask
  function automatic logic [14:0] model_exp(input int i);
    logic a, cs, wr, ld;
    a  = cyc == g[i] + 1;
    cs = cyc > g[i] && cyc <= g[i] + s_c[i] + w_c[i] + h_c[i];
    wr = cyc > g[i] + s_c[i] && cyc <= g[i] + s_c[i] + w_c[i];
    ld = cyc > l[i] && cyc <= l[i] + l_c[i];
    return {a & ~mab[i], a & mab[i], cs | ld, ~cs, ~wr, mab[i], md[i], ~ld};
  endfunction
  task automatic model_step(input int i);
    logic [14:0] e;
    logic ga, gb;
    ga = 1'b0;
    gb = 1'b0;
    e = model_exp(i);
    if (!rst) model_init(i);
    else begin
      if (cyc == l[i] + l_c[i]) begin
        wa[i] = 1'b0;
        wb[i] = 1'b0;
      end
      if (!e[12]) begin
        ga = ra[i] && (!rb[i] || last_b[i]);
        gb = rb[i] && (!ra[i] || !last_b[i]);
      end else if (cyc == g[i] + s_c[i] + w_c[i] + h_c[i]) begin
        ga = ra[i] && !wa[i];
        gb = rb[i] && !wb[i];
        if (!ga && !gb) l[i] = cyc;
      end
      if (ga || gb) begin
        g[i] = cyc;
        mab[i] = gb;
        md[i] = gb ? db[i] : da[i];
        last_b[i] = gb;
        if (gb) wb[i] = 1'b1;
        else wa[i] = 1'b1;
      end
    end
  endtask
  task automatic step();
    logic [14:0] e;
    for (int i = 0; i < 2; i++) begin
      e = model_exp(i);
      n_tests++;
      if (obs[i] !== e) begin
        n_fail++;
        $display("FAIL model%0d cyc %0d: got %b, expected %b (ack_a ack_b busy csn wrn a_b d[8] ldacn)", i, cyc, obs[i], e);
      end
    end
    for (int i = 0; i < 2; i++) model_step(i);
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic burst(input int n, input int a_at, input int b_at, input bit hold, input logic [7:0] va, input logic [7:0] vb,
                       output int aa, output int ab, output int nld, output int nwr, output int ng,
                       output logic [7:0] seq, output logic busy12);
    logic pl, pw;
    pl = 1'b1;
    pw = 1'b1;
    aa = -1; ab = -1; nld = 0; nwr = 0; ng = 0; seq = 8'h00; busy12 = 1'b1;
    for (int k = 0; k < n; k++) begin
      if (k == a_at) begin ra[0] = 1'b1; da[0] = va; end
      if (k == b_at) begin rb[0] = 1'b1; db[0] = vb; end
      if (bus0.ack_a) begin
        if (aa < 0) aa = k;
        seq = {seq[6:0], 1'b0};
        ng++;
        if (!hold) ra[0] = 1'b0;
      end
      if (bus0.ack_b) begin
        if (ab < 0) ab = k;
        seq = {seq[6:0], 1'b1};
        ng++;
        if (!hold) rb[0] = 1'b0;
      end
      if (pl && !bus0.dac_ldacn) nld++;
      if (pw && !bus0.dac_wrn) nwr++;
      pl = bus0.dac_ldacn;
      pw = bus0.dac_wrn;
      if (k == 12) busy12 = bus0.busy;
      step();
    end
    ra[0] = 1'b0;
    rb[0] = 1'b0;
  endtask
  typedef struct {
    logic       csn, wrn, ldacn, busy, ack;
    logic [7:0] d;
  } vec_t;
  initial begin
    vec_t tv [14];
    int aa, ab, nld, nwr, ng, k, ncs, nwl, nll, fw, bd, acks;
    logic [7:0] seq;
    logic b12, pb;
    for (int i = 0; i < 14; i++)
      tv[i] = '{csn: !(i >= 1 && i <= 8), wrn: !(i >= 3 && i <= 6), ldacn: !(i >= 9 && i <= 11),
                busy: i >= 1 && i <= 11, ack: i == 1, d: (i == 0) ? 8'h00 : 8'h5A};
    repeat (2) @(posedge clk);
    #1;
    model_init(0);
    model_init(1);
    chk("rst csn", bus0.dac_csn, 1);
    chk("rst wrn", bus0.dac_wrn, 1);
    chk("rst ldacn", bus0.dac_ldacn, 1);
    chk("rst a_b", bus0.dac_a_b, 0);
    chk("rst d", bus0.dac_d, 0);
    chk("rst busy", bus0.busy, 0);
    chk("rst ack", {bus0.ack_a, bus0.ack_b}, 0);
    rst = 1'b1;
    step();
    // single A write, every cycle of the transaction against the table
    ra[0] = 1'b1;
    da[0] = 8'h5A;
    for (int i = 0; i < 14; i++) begin
      chk($sformatf("t1[%0d] csn", i), bus0.dac_csn, tv[i].csn);
      chk($sformatf("t1[%0d] wrn", i), bus0.dac_wrn, tv[i].wrn);
      chk($sformatf("t1[%0d] ldacn", i), bus0.dac_ldacn, tv[i].ldacn);
      chk($sformatf("t1[%0d] busy", i), bus0.busy, tv[i].busy);
      chk($sformatf("t1[%0d] ack_a", i), bus0.ack_a, tv[i].ack);
      chk($sformatf("t1[%0d] d", i), bus0.dac_d, tv[i].d);
      chk($sformatf("t1[%0d] a_b", i), bus0.dac_a_b, 0);
      if (bus0.ack_a) ra[0] = 1'b0;
      step();
    end
    // simultaneous requests right after reset: A wins, B joins at A's HOLD exit
    rst = 1'b0;
    step();
    rst = 1'b1;
    burst(22, 0, 0, 1'b0, 8'h10, 8'hF0, aa, ab, nld, nwr, ng, seq, b12);
    chk("t2 ack_a", aa, 1);
    chk("t2 ack_b", ab, 9);
    chk("t2 wr pulses", nwr, 2);
    chk("t2 ldac pulses", nld, 1);
    burst(80, 0, 0, 1'b1, 8'($urandom), 8'($urandom), aa, ab, nld, nwr, ng, seq, b12);
    chk("t3 grants", ng, 8);
    chk("t3 order", seq, 8'h55);
    chk("t3 ldac pulses", nld, 4);
    burst(22, 0, 4, 1'b0, 8'h33, 8'hC4, aa, ab, nld, nwr, ng, seq, b12);
    chk("t4a ack_a", aa, 1);
    chk("t4a ack_b", ab, 9);
    chk("t4a ldac pulses", nld, 1);
    burst(26, 0, 10, 1'b0, 8'h77, 8'h8E, aa, ab, nld, nwr, ng, seq, b12);
    chk("t4b ack_a", aa, 1);
    chk("t4b ack_b", ab, 13);
    chk("t4b idle gap", b12, 0);
    chk("t4b ldac pulses", nld, 2);
    // reset while dac_wrn is low
    ra[0] = 1'b1;
    da[0] = 8'hA5;
    k = 0;
    while (bus0.dac_wrn && k < 20) begin
      if (bus0.ack_a) ra[0] = 1'b0;
      step();
      k++;
    end
    chk("t5 reached write", k < 20, 1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("t5 wrn", bus0.dac_wrn, 1);
    chk("t5 csn", bus0.dac_csn, 1);
    chk("t5 ldacn", bus0.dac_ldacn, 1);
    chk("t5 d", bus0.dac_d, 0);
    chk("t5 busy", bus0.busy, 0);
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      acks += int'(bus0.ack_a) + int'(bus0.ack_b);
      step();
    end
    chk("t5 no ack", acks, 0);
    burst(14, 0, -1, 1'b0, 8'h3C, 8'h00, aa, ab, nld, nwr, ng, seq, b12);
    chk("t5 recover ack", aa, 1);
    chk("t5 recover wr", nwr, 1);
    chk("t5 recover ldac", nld, 1);
    // corner parameters on the second instance
    ra[1] = 1'b1;
    da[1] = 8'hC3;
    ncs = 0; nwl = 0; nll = 0; fw = -1; bd = -1; pb = 1'b0;
    for (int i = 0; i < 265; i++) begin
      if (bus1.ack_a) ra[1] = 1'b0;
      ncs += int'(!bus1.dac_csn);
      nwl += int'(!bus1.dac_wrn);
      nll += int'(!bus1.dac_ldacn);
      if (fw < 0 && !bus1.dac_wrn) fw = i;
      if (bd < 0 && pb && !bus1.busy) bd = i;
      pb = bus1.busy;
      step();
    end
    chk("t6 csn low", ncs, 257);
    chk("t6 wrn low", nwl, 255);
    chk("t6 ldacn low", nll, 1);
    chk("t6 wrn start", fw, 2);
    chk("t6 busy drop", bd, 259);
    // random traffic on both instances with occasional resets
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!ra[i]) begin
          if ($urandom_range(0, 3) == 0) begin ra[i] = 1'b1; da[i] = 8'($urandom); end
        end else if (obs[i][14]) begin
          if ($urandom_range(0, 3) != 0) ra[i] = 1'b0;
          else da[i] = 8'($urandom);
        end else if ($urandom_range(0, 99) == 0) ra[i] = 1'b0;
        if (!rb[i]) begin
          if ($urandom_range(0, 3) == 0) begin rb[i] = 1'b1; db[i] = 8'($urandom); end
        end else if (obs[i][13]) begin
          if ($urandom_range(0, 3) != 0) rb[i] = 1'b0;
          else db[i] = 8'($urandom);
        end else if ($urandom_range(0, 99) == 0) rb[i] = 1'b0;
      end
      rst = $urandom_range(0, 499) != 0;
      step();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dac_write_scheduler.md
Name: dac_write_scheduler

Overview:
Shares the dual-channel 8-bit parallel DAC between two requesters, channel A and channel B, using a req/ack handshake and round-robin arbitration.
Generates the DAC bus timing: dac_csn, dac_wrn, dac_a_b, dac_d and dac_ldacn.
Batches back-to-back A/B writes so both outputs update on a single dac_ldacn pulse.
Sits between the user/value-generation logic and the DAC pins; it replaces free-running DAC write timing.

Parameters:
SETUP_CYC, 4, cycles that dac_csn/dac_a_b/dac_d are valid before dac_wrn falls (legal range 1..255)
WR_CYC, 50, cycles that dac_wrn is held low (1..255)
HOLD_CYC, 4, cycles that data/address are held after dac_wrn rises (1..255)
LDAC_CYC, 8, cycles that dac_ldacn is held low (1..255)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-low reset
req_a  in  1  channel A write request; held until ack_a
data_a  in  8  channel A code; sampled on the grant edge
ack_a  out  1  one-cycle pulse: data_a captured
req_b  in  1  channel B write request; held until ack_b
data_b  in  8  channel B code; sampled on the grant edge
ack_b  out  1  one-cycle pulse: data_b captured
busy  out  1  high whenever state != IDLE
dac_csn  out  1  DAC chip select, active low
dac_wrn  out  1  DAC write strobe, active low
dac_a_b  out  1  DAC channel select: 0 = A, 1 = B
dac_d  out  8  DAC data bus
dac_ldacn  out  1  DAC load strobe, active low

Behaviour:
- Reset (rst=0 at a clock edge) forces the following, regardless of state:
  - state=IDLE, dac_csn=1, dac_wrn=1, dac_ldacn=1, dac_a_b=0, dac_d=0x00;
  - ack_a=0, ack_b=0, busy=0, last_grant=B, batch flags cleared.
  - Reset mid-operation discards latched data, issues no ack, and resumes at IDLE.
- All outputs are registered. A single 8-bit down-counter times every state; each timed state lasts exactly its parameter in cycles.
- IDLE: outputs are at their idle values.
  - If exactly one req is high, grant that channel.
  - If both are high, grant the channel != last_grant. After reset, A wins the first tie.
- Grant edge, registered:
  - ack_x=1 for one cycle; dac_d<=data_x; dac_a_b<=x; dac_csn<=0;
  - last_grant<=x; mark x written in this batch; state<=SETUP.
- SETUP: lasts SETUP_CYC cycles with dac_csn=0, then state<=WRITE.
- WRITE: dac_wrn=0 for WR_CYC cycles, then state<=HOLD.
- HOLD: dac_wrn=1, with dac_d/dac_a_b/dac_csn unchanged, for HOLD_CYC cycles. At HOLD exit:
  - if the other channel's req is high and not yet written this batch, grant it on this edge (same actions as the grant edge) and go to SETUP, skipping LOAD;
  - otherwise dac_csn<=1 and state<=LOAD.
- LOAD: dac_ldacn=0 for LDAC_CYC cycles. At exit: dac_ldacn<=1, clear batch flags, state<=IDLE.
- IDLE is held for at least 1 cycle between batches; a batch holds at most 2 writes (A then B, or B then A).
- dac_d and dac_a_b change only on grant edges; they hold their value through IDLE.
- A req that drops before ack is simply not serviced; no error is raised.
- A req that stays high after ack is treated as a new request in a later batch.
- The same channel is never written twice in one batch.
- The write count per grant is SETUP_CYC+WR_CYC+HOLD_CYC cycles, exact with no off-by-one; the bench checks it.

Test Plan:
(Parameters SETUP=2, WR=4, HOLD=2, LDAC=3 unless stated.)
1. Single A write: req_a=1, data_a=0x5A at IDLE cycle t.
   Required: ack_a at t+1; dac_csn=0 for t+1..t+8; dac_wrn=0 exactly t+3..t+6; dac_d=0x5A, dac_a_b=0 throughout; dac_ldacn=0 t+9..t+11; busy drops at t+12.
2. Simultaneous req_a/req_b first after reset, data 0x10/0xF0.
   Required: A granted first; B granted on the A HOLD exit edge; two dac_wrn pulses (A then B); exactly one dac_ldacn pulse after B's HOLD.
3. Both reqs held continuously for 4 batches.
   Required: grant order alternates A, B, A, B; no starvation; each batch has exactly one ldacn pulse.
4. B request arrives mid-A-WRITE.
   Required: B joins the same batch at the A HOLD exit. If B arrives during A's LOAD instead, it is serviced in the next batch after ≥1 IDLE cycle.
5. rst=0 asserted during WRITE.
   Required: next edge gives dac_wrn=1, dac_csn=1, dac_ldacn=1, dac_d=0x00, busy=0, no ack. After release, a new req_a completes normally.
6. Parameter corners SETUP=HOLD=LDAC=1, WR=255.
   Required: each phase length matches exactly; the counter does not wrap early.
